// File: rtl/pwm_duty_sequencer_if.sv
// Remote duty command channel: sender holds valid and duty until ready is seen.
interface pwm_duty_sequencer_if;
  logic       remote_valid;
  logic [3:0] remote_duty;
  logic       remote_ready;

  modport master (output remote_valid, output remote_duty, input remote_ready);
  modport slave  (input remote_valid, input remote_duty, output remote_ready);
endinterface

// File: rtl/pwm_duty_sequencer.sv
// Glitch-free LED duty sequencer: debounced local switches or remote commands pick
// the target, and duty walks toward it one step per RAMP_PERIODS PWM periods.
module pwm_duty_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RAMP_PERIODS    = 4,
  parameter int HOLD_PERIODS    = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [3:0]          switches,
  input  logic                pwm_wrap,
  pwm_duty_sequencer_if.slave remote,
  output logic [3:0]          duty,
  output logic                duty_update,
  output logic                owner_remote
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = $clog2(RAMP_PERIODS + 1);
  localparam int HW = (HOLD_PERIODS > 0) ? $clog2(HOLD_PERIODS + 1) : 1;

  typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN} state_t;

  state_t        state;
  logic [3:0]    sync1, sync2, candidate, debounced, target;
  logic [DW-1:0] stable_cnt;
  logic [RW-1:0] ramp_cnt;
  logic [HW-1:0] hold_cnt;
  logic          accept, revert;

  assign remote.remote_ready = !reset && (state == IDLE);
  assign accept = remote.remote_valid && remote.remote_ready;
  assign revert = (HOLD_PERIODS != 0) && owner_remote && (state == IDLE) &&
                  (hold_cnt == HW'(HOLD_PERIODS));

  // Any change of the synced value restarts the stability window.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1      <= '0;
      sync2      <= '0;
      candidate  <= '0;
      stable_cnt <= '0;
      debounced  <= '0;
    end else begin
      sync1 <= switches;
      sync2 <= sync1;
      if (sync2 != candidate) begin
        candidate  <= sync2;
        stable_cnt <= '0;
      end else if (stable_cnt != DW'(DEBOUNCE_CYCLES)) begin
        stable_cnt <= stable_cnt + DW'(1);
        if (stable_cnt == DW'(DEBOUNCE_CYCLES - 1)) debounced <= candidate;
      end
    end
  end

  // Ownership and target; an accept overrides a simultaneous revert.
  always_ff @(posedge clock) begin
    if (reset) begin
      target       <= '0;
      owner_remote <= 1'b0;
      hold_cnt     <= '0;
    end else begin
      if (accept || revert || state != IDLE)
        hold_cnt <= '0;
      else if (owner_remote && pwm_wrap && hold_cnt != HW'(HOLD_PERIODS))
        hold_cnt <= hold_cnt + HW'(1);

      if (accept) begin
        target       <= remote.remote_duty;
        owner_remote <= 1'b1;
      end else if (revert) begin
        target       <= debounced;
        owner_remote <= 1'b0;
      end else if (!owner_remote) begin
        target <= debounced;
      end
    end
  end

  // Ramp FSM; direction is re-derived every cycle so a crossing retarget keeps ramp_cnt.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      ramp_cnt    <= '0;
      duty        <= '0;
      duty_update <= 1'b0;
    end else begin
      duty_update <= 1'b0;
      case (state)
        IDLE: begin
          if (target > duty) begin
            state    <= RAMP_UP;
            ramp_cnt <= '0;
          end else if (target < duty) begin
            state    <= RAMP_DOWN;
            ramp_cnt <= '0;
          end
        end
        default: begin
          if (target == duty) begin
            state <= IDLE;
          end else begin
            state <= (target > duty) ? RAMP_UP : RAMP_DOWN;
            if (pwm_wrap) begin
              if (ramp_cnt == RW'(RAMP_PERIODS - 1)) begin
                ramp_cnt    <= '0;
                duty_update <= 1'b1;
                duty        <= (target > duty) ? duty + 4'd1 : duty - 4'd1;
              end else begin
                ramp_cnt <= ramp_cnt + RW'(1);
              end
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Bench for pwm_duty_sequencer: directed scenarios plus randomized traffic against a
// behavioural model of the selection, debounce and ramp rules.
module tb_pwm_duty_sequencer;
  localparam int DEB = 4, RAMP = 2, HOLD = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] switches = 4'h0;
  logic       pwm_wrap = 1'b0;
  logic [3:0] duty;
  logic       duty_update, owner_remote;

  int checks = 0, errors = 0, cyc = 0;
  bit wrap_rand = 1'b0;

  pwm_duty_sequencer_if rif();

  pwm_duty_sequencer #(.DEBOUNCE_CYCLES(DEB), .RAMP_PERIODS(RAMP), .HOLD_PERIODS(HOLD)) dut (
    .clock(clock), .reset(reset), .switches(switches), .pwm_wrap(pwm_wrap),
    .remote(rif), .duty(duty), .duty_update(duty_update), .owner_remote(owner_remote)
  );

  always #5 clock = ~clock;

  // Reference model: debounce as a run length of the twice-delayed switches, ramp as a
  // "busy" flag with a wrap progress count, direction taken from sign(target - duty).
  int m_s1, m_s2, m_last, m_run, m_deb, m_tgt, m_duty, m_prog, m_hold;
  bit m_own, m_busy, m_upd, m_acc;
  int o_deb, o_tgt, o_duty, o_hold;
  bit o_own, o_busy, rev;

  always @(posedge clock) begin
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_last = 0; m_run = 0; m_deb = 0; m_tgt = 0; m_duty = 0;
      m_prog = 0; m_hold = 0; m_own = 0; m_busy = 0; m_upd = 0; m_acc = 0;
    end else begin
      o_deb = m_deb; o_tgt = m_tgt; o_duty = m_duty; o_hold = m_hold;
      o_own = m_own; o_busy = m_busy;
      m_acc = rif.remote_valid && !o_busy;
      if (m_s2 != m_last) begin
        m_last = m_s2; m_run = 0;
      end else begin
        m_run++;
        if (m_run == DEB) m_deb = m_last;
      end
      m_s2 = m_s1; m_s1 = int'(switches);
      m_upd = 0;
      if (!o_busy) begin
        if (o_tgt != o_duty) begin m_busy = 1; m_prog = 0; end
      end else if (o_tgt == o_duty) begin
        m_busy = 0;
      end else if (pwm_wrap) begin
        m_prog++;
        if (m_prog == RAMP) begin
          m_prog = 0; m_upd = 1;
          m_duty = (o_tgt > o_duty) ? o_duty + 1 : o_duty - 1;
        end
      end
      rev = o_own && !o_busy && HOLD != 0 && o_hold == HOLD;
      if (o_busy) m_hold = 0;
      else if (o_own && pwm_wrap && o_hold < HOLD) m_hold = o_hold + 1;
      if (m_acc) begin
        m_tgt = int'(rif.remote_duty); m_own = 1; m_hold = 0;
      end else if (rev) begin
        m_tgt = o_deb; m_own = 0; m_hold = 0;
      end else if (!o_own) begin
        m_tgt = o_deb;
      end
    end
  end

  function automatic logic [6:0] obs();
    return {duty, duty_update, owner_remote, rif.remote_ready};
  endfunction

  function automatic logic [6:0] exp_v();
    return {4'(m_duty), m_upd, m_own, !reset && !m_busy};
  endfunction

  task automatic tick();
    @(posedge clock); #1;
    cyc++;
    pwm_wrap = wrap_rand ? ($urandom_range(0, 3) == 0) : (cyc % 16 == 0);
  endtask

  task automatic start(input logic [3:0] sw);
    reset = 1'b1; rif.remote_valid = 1'b0; switches = sw; wrap_rand = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; switches = 4'hA; rif.remote_valid = 1'b1; rif.remote_duty = 4'h5;
    tick(); tick();
    checks++;
    if (obs() !== 7'h00) begin
      errors++; $display("FAIL reset_state got=%h exp=00", obs());
    end
    rif.remote_valid = 1'b0; reset = 1'b0; #1;
    checks++;
    if (rif.remote_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready got=%b exp=1", rif.remote_ready);
    end
  endtask

  task automatic test_local_ramp();
    int ups = 0; bit pw; bit done = 0;
    start(4'hF);
    for (int i = 0; i < 800; i++) begin
      pw = pwm_wrap; tick();
      checks++;
      if (obs() !== exp_v()) begin
        errors++; $display("FAIL ramp_model cyc=%0d got=%h exp=%h", cyc, obs(), exp_v());
      end
      if (duty_update) begin
        ups++; checks++;
        if (!pw) begin errors++; $display("FAIL ramp_update_on_wrap cyc=%0d got wrap=0 exp wrap=1", cyc); end
      end
      if (duty == 4'hF && rif.remote_ready) begin done = 1; break; end
    end
    checks++;
    if (!done || ups != 15) begin
      errors++; $display("FAIL ramp_full got done=%0d ups=%0d exp done=1 ups=15", done, ups);
    end
  endtask

  task automatic test_glitch();
    start(4'h0);
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) switches = (switches == 4'h0) ? 4'h5 : 4'h0;
      tick();
      checks++;
      if (duty !== 4'h0 || duty_update !== 1'b0 || obs() !== exp_v()) begin
        errors++; $display("FAIL glitch cyc=%0d got=%h exp=%h", cyc, obs(), exp_v());
      end
    end
  endtask

  task automatic test_remote();
    int ups = 0, wraps = 0, bad_ready = 0; bit pw; bit done = 0;
    start(4'hF);
    for (int i = 0; i < 800; i++) begin
      tick();
      if (duty == 4'hF && rif.remote_ready) break;
    end
    rif.remote_valid = 1'b1; rif.remote_duty = 4'd3;
    tick();
    if (m_acc) rif.remote_valid = 1'b0;
    checks++;
    if (owner_remote !== 1'b1) begin
      errors++; $display("FAIL remote_accept got owner=%b exp=1", owner_remote);
    end
    tick();
    for (int i = 0; i < 800; i++) begin
      tick();
      checks++;
      if (obs() !== exp_v()) begin
        errors++; $display("FAIL remote_model cyc=%0d got=%h exp=%h", cyc, obs(), exp_v());
      end
      if (duty_update) ups++;
      if (duty != 4'd3 && rif.remote_ready) bad_ready++;
      if (duty == 4'd3 && rif.remote_ready) begin done = 1; break; end
    end
    checks++;
    if (!done || ups != 12 || bad_ready != 0) begin
      errors++; $display("FAIL remote_ramp got done=%0d ups=%0d bad_ready=%0d exp 1 12 0", done, ups, bad_ready);
    end
    for (int i = 0; i < 200; i++) begin
      pw = pwm_wrap; tick();
      if (pw) wraps++;
      if (!owner_remote) break;
    end
    checks++;
    if (wraps != 3 || owner_remote !== 1'b0 || duty !== 4'd3) begin
      errors++; $display("FAIL remote_hold got wraps=%0d owner=%b duty=%0d exp 3 0 3", wraps, owner_remote, duty);
    end
    done = 0;
    for (int i = 0; i < 800; i++) begin
      tick();
      checks++;
      if (obs() !== exp_v()) begin
        errors++; $display("FAIL revert_model cyc=%0d got=%h exp=%h", cyc, obs(), exp_v());
      end
      if (duty == 4'hF && rif.remote_ready) begin done = 1; break; end
    end
    checks++;
    if (!done) begin errors++; $display("FAIL revert_ramp got duty=%0d exp=15", duty); end
  endtask

  task automatic test_held_cmd();
    int since15 = -1; bit done = 0;
    start(4'hF);
    for (int i = 0; i < 400; i++) begin
      tick();
      if (duty == 4'd4) break;
    end
    rif.remote_valid = 1'b1; rif.remote_duty = 4'd7;
    for (int i = 0; i < 800; i++) begin
      tick();
      if (m_acc) rif.remote_valid = 1'b0;
      checks++;
      if (obs() !== exp_v()) begin
        errors++; $display("FAIL held_model cyc=%0d got=%h exp=%h", cyc, obs(), exp_v());
      end
      if (since15 >= 0) since15++;
      else if (duty == 4'hF) since15 = 0;
      if (owner_remote) break;
    end
    checks++;
    if (since15 != 2 || duty !== 4'hF) begin
      errors++; $display("FAIL held_accept_first_idle got delay=%0d duty=%0d exp 2 15", since15, duty);
    end
    for (int i = 0; i < 600; i++) begin
      tick();
      if (duty == 4'd7 && rif.remote_ready) begin done = 1; break; end
    end
    checks++;
    if (!done || owner_remote !== 1'b1) begin
      errors++; $display("FAIL held_target got duty=%0d owner=%b exp 7 1", duty, owner_remote);
    end
  endtask

  task automatic test_retarget();
    int prev = 6, steps = 0; bit mono = 1, done = 0;
    start(4'hF);
    for (int i = 0; i < 400; i++) begin
      tick();
      if (duty == 4'd6) break;
    end
    switches = 4'd2;
    for (int i = 0; i < 400; i++) begin
      tick();
      checks++;
      if (obs() !== exp_v()) begin
        errors++; $display("FAIL retarget_model cyc=%0d got=%h exp=%h", cyc, obs(), exp_v());
      end
      if (int'(duty) != prev) begin
        steps++;
        if (int'(duty) != prev - 1) mono = 0;
        prev = int'(duty);
      end
      if (duty == 4'd2 && rif.remote_ready) begin done = 1; break; end
    end
    checks++;
    if (!done || !mono || steps != 4) begin
      errors++; $display("FAIL retarget_steps got done=%0d mono=%0d steps=%0d exp 1 1 4", done, mono, steps);
    end
  endtask

  task automatic test_reset_mid();
    start(4'hF);
    for (int i = 0; i < 400; i++) begin
      tick();
      if (duty == 4'd9) break;
    end
    reset = 1'b1; #1;
    checks++;
    if (rif.remote_ready !== 1'b0 || duty !== 4'd9) begin
      errors++; $display("FAIL midreset_during got ready=%b duty=%0d exp 0 9", rif.remote_ready, duty);
    end
    tick();
    reset = 1'b0; #1;
    checks++;
    if (obs() !== 7'h01) begin
      errors++; $display("FAIL midreset_after got=%h exp=01", obs());
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if (obs() !== exp_v()) begin
        errors++; $display("FAIL midreset_model cyc=%0d got=%h exp=%h", cyc, obs(), exp_v());
      end
    end
  endtask

  task automatic test_random();
    int sw_hold = 0;
    start(4'h0);
    wrap_rand = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      tick();
      if (m_acc) rif.remote_valid = 1'b0;
      checks++;
      if (obs() !== exp_v()) begin
        errors++; $display("FAIL random_model cyc=%0d got=%h exp=%h", cyc, obs(), exp_v());
      end
      reset = ($urandom_range(0, 999) == 0);
      if (sw_hold == 0) begin
        switches = 4'($urandom);
        sw_hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 60);
      end else sw_hold--;
      if (!rif.remote_valid && $urandom_range(0, 50) == 0) begin
        rif.remote_valid = 1'b1; rif.remote_duty = 4'($urandom);
      end
    end
    reset = 1'b0; wrap_rand = 1'b0;
  endtask

  initial begin
    rif.remote_valid = 1'b0; rif.remote_duty = 4'h0;
    test_reset();
    test_local_ramp();
    test_glitch();
    test_remote();
    test_held_cmd();
    test_retarget();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
